// File: rtl/race_sample_feeder.sv
// race_sample_feeder: upstream driver for the RACE adaptive filter.
// Buffers complex samples from a valid/ready stream in a small FIFO and feeds them to the
// filter one at a time: strobe_resync pulse, then valid_in pulse, then wait for data_ready.
//
// Optional feature macro: RACE_FEEDER_WDOG_EN
//   defined   : WAIT is bounded by TIMEOUT cycles; a timeout sets sticky timeout_err and
//               drops the sample.
//   undefined : WAIT lasts until data_ready; timeout_err is tied low.
//
// Ports:
//   clk           clock, rising edge
//   nrst          asynchronous active-low reset
//   s_valid/s_ready/s_real/s_imag  upstream sample stream (s_ready = !full)
//   strobe_resync one-cycle pulse restarting the filter tap sequencer
//   valid_in      one-cycle pulse, the cycle after strobe_resync
//   in_real/in_imag  sample held from pop until the next pop
//   data_ready    filter result-ready pulse
//   busy          high whenever the FSM is not idle
//   fifo_level    FIFO occupancy
//   timeout_err   sticky watchdog flag
module race_sample_feeder #(
    parameter int unsigned SAMPLE_SIZE = 16,
    parameter int unsigned L           = 7,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT     = 4 * L + 8
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [SAMPLE_SIZE-1:0]          s_real,
    input  logic [SAMPLE_SIZE-1:0]          s_imag,
    output logic                            strobe_resync,
    output logic                            valid_in,
    output logic [SAMPLE_SIZE-1:0]          in_real,
    output logic [SAMPLE_SIZE-1:0]          in_imag,
    input  logic                            data_ready,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            timeout_err
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    // Reject configurations the pointer arithmetic cannot handle.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || L < 1 || TIMEOUT < 1)
    begin : g_bad_param
        $error("race_sample_feeder: illegal parameter set");
    end

    typedef enum logic [1:0] {StIdle, StStrobe, StLaunch, StWait} state_e;

    state_e                   state_q;
    logic [2*SAMPLE_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]          level_q, level_d;
    logic [SAMPLE_SIZE-1:0]   real_q, imag_q;
    logic                     strobe_q, valid_q;
    logic                     full, push, pop, timeout_hit;

    // No pass-through: s_ready depends only on the registered level.
    assign full = (level_q == LvlW'(FIFO_DEPTH));
    assign push = s_valid && !full;
    assign pop  = (state_q == StIdle) && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_real, s_imag};
    end

`ifdef RACE_FEEDER_WDOG_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            terr_q;

    assign timeout_hit = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            if (state_q == StLaunch) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            // data_ready takes priority over a coincident timeout.
            if (timeout_hit && !data_ready) terr_q <= 1'b1;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            real_q   <= '0;
            imag_q   <= '0;
        end else begin
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        {real_q, imag_q} <= mem_q[rd_ptr_q];
                        strobe_q         <= 1'b1;
                        state_q          <= StStrobe;
                    end
                end
                StStrobe: begin
                    valid_q <= 1'b1;
                    state_q <= StLaunch;
                end
                StLaunch: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (data_ready || timeout_hit) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_ready       = !full;
    assign strobe_resync = strobe_q;
    assign valid_in      = valid_q;
    assign in_real       = real_q;
    assign in_imag       = imag_q;
    assign busy          = (state_q != StIdle);
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_race_sample_feeder.sv
// Scoreboard bench for race_sample_feeder: the driver queues each accepted sample, and a monitor
// pops and compares whenever valid_in is presented. Timing and flag checks use directed values.
module tb_race_sample_feeder;

    localparam int unsigned SS = 16;
    localparam int unsigned LW = $clog2(8 + 1);

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [SS-1:0] s_real = '0;
    logic [SS-1:0] s_imag = '0;
    logic          strobe_resync;
    logic          valid_in;
    logic [SS-1:0] in_real;
    logic [SS-1:0] in_imag;
    logic          data_ready = 1'b0;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic          timeout_err;

    race_sample_feeder dut (
        .clk          (clk),
        .nrst         (nrst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_real       (s_real),
        .s_imag       (s_imag),
        .strobe_resync(strobe_resync),
        .valid_in     (valid_in),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .data_ready   (data_ready),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [2*SS-1:0] exp_q[$];
    int              strobe_t[$];
    int              valid_t[$];
    int              strobe_cnt = 0;
    logic            prev_strobe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sample away from the rising edge.
    always @(negedge clk) begin
        if (strobe_resync) begin
            strobe_t.push_back(cyc);
            strobe_cnt = strobe_cnt + 1;
        end
        if (valid_in) begin
            valid_t.push_back(cyc);
            check("valid_after_strobe", {31'd0, prev_strobe}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 32'd1, 32'd0);
            end else begin
                logic [2*SS-1:0] e;
                e = exp_q.pop_front();
                check("sample_real", {16'd0, in_real}, {16'd0, e[2*SS-1:SS]});
                check("sample_imag", {16'd0, in_imag}, {16'd0, e[SS-1:0]});
            end
        end
        prev_strobe = strobe_resync;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SS-1:0] r, input logic [SS-1:0] i, output bit acc);
        s_valid = 1'b1;
        s_real  = r;
        s_imag  = i;
        acc     = s_ready;
        if (acc) exp_q.push_back({r, i});
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int b = 0;
        while (strobe_cnt < n && b < 300) begin
            step();
            b++;
        end
        check("strobe_arrived", {31'd0, strobe_cnt >= n}, 32'd1);
    endtask

    // data_ready 17 cycles after strobe idx, then confirm busy drops the next cycle.
    task automatic serve(input int idx);
        int target;
        int b = 0;
        wait_strobes(idx + 1);
        target = (strobe_t.size() > idx) ? strobe_t[idx] + 17 : cyc;
        while (cyc < target && b < 300) begin
            step();
            b++;
        end
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("busy_drop", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #2;
        exp_q.delete();
        nrst = 1'b1;
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int a;
        int base;
        int n_acc;
        int s0;

        // Reset values.
        #2;
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_strobe", {31'd0, strobe_resync}, 32'd0);
        check("rst_valid", {31'd0, valid_in}, 32'd0);
        check("rst_in_real", {16'd0, in_real}, 32'd0);
        check("rst_in_imag", {16'd0, in_imag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {28'd0, fifo_level}, 32'd0);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        #1;
        nrst = 1'b1;
        step();

        // 1: single sample latency and hold.
        a = cyc;
        push(16'h1234, 16'hFEDC, acc);
        check("t1_accept", {31'd0, acc}, 32'd1);
        check("t1_level_after_push", {28'd0, fifo_level}, 32'd1);
        check("t1_idle_at_pop", {31'd0, busy}, 32'd0);
        serve(0);
        check("t1_strobe_cycle", strobe_t[0], a + 2);
        check("t1_valid_cycle", (valid_t.size() > 0) ? valid_t[0] : -1, a + 3);
        check("t1_hold_real", {16'd0, in_real}, 32'h1234);
        check("t1_hold_imag", {16'd0, in_imag}, 32'hFEDC);
        check("t1_level_end", {28'd0, fifo_level}, 32'd0);

        // 2: fill the FIFO while the filter never answers.
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            push(16'h2000 + 16'(k), 16'h3000 + 16'(k), acc);
            n_acc += int'(acc);
        end
        check("t2_level_7", {28'd0, fifo_level}, 32'd7);
        check("t2_busy", {31'd0, busy}, 32'd1);
        for (int k = 8; k < 17; k++) begin
            push(16'h2000 + 16'(k), 16'h3000 + 16'(k), acc);
            n_acc += int'(acc);
        end
        check("t2_accepted", n_acc, 9);
        check("t2_level_full", {28'd0, fifo_level}, 32'd8);
        check("t2_s_ready_full", {31'd0, s_ready}, 32'd0);
        do_reset();
        check("t2_level_after_rst", {28'd0, fifo_level}, 32'd0);

        // 3: four queued samples served in FIFO order.
        base = strobe_cnt;
        push(16'hA001, 16'h5001, acc);
        push(16'hA002, 16'h5002, acc);
        push(16'hA003, 16'h5003, acc);
        push(16'hA004, 16'h5004, acc);
        for (int k = 0; k < 4; k++) serve(base + k);
        // data_ready at strobe+17 -> IDLE at +18, next strobe at +19.
        for (int k = 0; k < 3; k++) begin
            check("t3_strobe_spacing",
                  (strobe_t.size() > base + k + 1) ? strobe_t[base+k+1] - strobe_t[base+k] : -1,
                  19);
        end
        check("t3_level_end", {28'd0, fifo_level}, 32'd0);
        check("t3_queue_drained", exp_q.size(), 0);

        // 6: data_ready in IDLE and STROBE is ignored.
        base = strobe_cnt;
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("t6_idle_ignored", {31'd0, busy}, 32'd0);
        push(16'h6161, 16'h7171, acc);
        data_ready = 1'b1;  // IDLE cycle with pop
        step();
        check("t6_strobe_state", {31'd0, strobe_resync}, 32'd1);
        step();             // STROBE cycle consumed the pulse
        data_ready = 1'b0;
        check("t6_launch", {31'd0, valid_in}, 32'd1);
        for (int k = 0; k < 4; k++) step();
        check("t6_still_busy", {31'd0, busy}, 32'd1);
        serve(base);

        // 4: watchdog.
        base = strobe_cnt;
`ifdef RACE_FEEDER_WDOG_EN
        push(16'h4444, 16'h0004, acc);
        push(16'h4545, 16'h0005, acc);
        wait_strobes(base + 1);
        s0 = (strobe_t.size() > base) ? strobe_t[base] : cyc;
        // WAIT spans s0+2 .. s0+37 (36 cycles), IDLE at s0+38.
        while (cyc < s0 + 38) step();
        check("t4_idle_after_timeout", {31'd0, busy}, 32'd0);
        check("t4_terr_set", {31'd0, timeout_err}, 32'd1);
        wait_strobes(base + 2);
        check("t4_next_strobe", (strobe_t.size() > base + 1) ? strobe_t[base+1] : -1, s0 + 39);
        serve(base + 1);
        check("t4_terr_sticky", {31'd0, timeout_err}, 32'd1);
`else
        push(16'h4444, 16'h0004, acc);
        wait_strobes(base + 1);
        s0 = (strobe_t.size() > base) ? strobe_t[base] : cyc;
        while (cyc < s0 + 60) step();
        check("t4_wait_forever", {31'd0, busy}, 32'd1);
        check("t4_terr_tied", {31'd0, timeout_err}, 32'd0);
        serve(base);
`endif

        // 5: asynchronous reset in WAIT with three samples queued.
        push(16'h5555, 16'h0001, acc);
        push(16'h5556, 16'h0002, acc);
        push(16'h5557, 16'h0003, acc);
        push(16'h5558, 16'h0004, acc);
        check("t5_level_3", {28'd0, fifo_level}, 32'd3);
        check("t5_busy", {31'd0, busy}, 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        check("t5_s_ready", {31'd0, s_ready}, 32'd1);
        check("t5_strobe", {31'd0, strobe_resync}, 32'd0);
        check("t5_valid", {31'd0, valid_in}, 32'd0);
        check("t5_in_real", {16'd0, in_real}, 32'd0);
        check("t5_in_imag", {16'd0, in_imag}, 32'd0);
        check("t5_busy_rst", {31'd0, busy}, 32'd0);
        check("t5_level_rst", {28'd0, fifo_level}, 32'd0);
        check("t5_terr_rst", {31'd0, timeout_err}, 32'd0);
        exp_q.delete();
        base = strobe_cnt;
        nrst = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("t5_no_strobe", strobe_cnt, base);
        check("t5_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
